// File: rtl/byte_stream_gen_if.sv
// Byte-side bus of the P2B byte-stream source: burst request inputs and packed payload outputs.
// The generator drives through the master modport; a consumer or bench uses the slave modport.
interface byte_stream_gen_if #(
  parameter int NUM_TX_LANE = 1,
  parameter int TX_GEAR     = 8,
  parameter int LEN_W       = 16
);
  logic                         start;
  logic [LEN_W-1:0]             byte_len;
  logic [7:0]                   seed;
  logic                         hold;
  logic                         byte_en;
  logic [NUM_TX_LANE*TX_GEAR-1:0] byte_dout;
  logic                         byte_last;
  logic                         busy;
  logic                         done;
  logic [LEN_W-1:0]             byte_cnt;

  modport master (
    input  start, byte_len, seed, hold,
    output byte_en, byte_dout, byte_last, busy, done, byte_cnt
  );

  modport slave (
    output start, byte_len, seed, hold,
    input  byte_en, byte_dout, byte_last, busy, done, byte_cnt
  );
endinterface

// File: rtl/byte_stream_gen.sv
// Incrementing-pattern byte burst source packed BPW bytes per word; first word 2 cycles after start.
// hold stalls emission with all burst state frozen; start is only accepted in IDLE.
module byte_stream_gen #(
  parameter int NUM_TX_LANE = 1,
  parameter int TX_GEAR     = 8,
  parameter int LEN_W       = 16
) (
  input  logic                byte_clk,
  input  logic                reset_n,
  byte_stream_gen_if.master   bus
);
  localparam int W   = NUM_TX_LANE * TX_GEAR;
  localparam int BPW = W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic [7:0]       next_val;
  logic             en_q;
  logic [W-1:0]     dout_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic [LEN_W-1:0] cnt_q;

  logic [LEN_W-1:0] take;
  logic [W-1:0]     word;
  logic             final_word;

  // Lanes beyond the remaining byte count are zero-filled on the short final word.
  always_comb begin
    take       = (remaining < LEN_W'(BPW)) ? remaining : LEN_W'(BPW);
    final_word = (remaining <= LEN_W'(BPW));
    word       = '0;
    for (int k = 0; k < BPW; k++) begin
      if (LEN_W'(k) < remaining)
        word[8*k +: 8] = next_val + 8'(k);
    end
  end

  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      next_val  <= '0;
      en_q      <= 1'b0;
      dout_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          en_q   <= 1'b0;
          last_q <= 1'b0;
          if (bus.start) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.byte_len != '0) begin
              remaining <= bus.byte_len;
              next_val  <= bus.seed;
              state     <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (bus.hold) begin
            en_q   <= 1'b0;
            last_q <= 1'b0;
          end else begin
            en_q      <= 1'b1;
            dout_q    <= word;
            cnt_q     <= cnt_q + take;
            remaining <= remaining - take;
            next_val  <= next_val + 8'(BPW);
            last_q    <= final_word;
            if (final_word)
              state <= DONE;
          end
        end
        DONE: begin
          en_q   <= 1'b0;
          last_q <= 1'b0;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          en_q   <= 1'b0;
          last_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.byte_en   = en_q;
  assign bus.byte_dout = dout_q;
  assign bus.byte_last = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.byte_cnt  = cnt_q;
endmodule
